bpsk_frame_tx: RTL and testbench

- Upstream framer for the BPSK transmitter.
- Accepts payload bytes over a valid/ready stream and wraps them in a frame: preamble, sync word, length, payload, XOR checksum.
- Serializes the frame MSB-first as an NRZ bit on DATA at the symbol rate, which drives the modulator's DATA input directly.
- Paces bits from the 100 MHz system clock; no external baud strobe.

---
 rtl/bpsk_frame_pkg.sv | 21 ++
 rtl/bpsk_frame_tx_baud.sv | 35 +++
 rtl/bpsk_frame_tx.sv | 213 +++++++++++++++++++++
 tb/tb_bpsk_frame_tx.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpsk_frame_pkg.sv
// Shared definitions for the BPSK frame transmitter: state encoding,
// preamble byte, default sync word and bit-counter width.
package bpsk_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SYNC,
        ST_LENGTH,
        ST_PAYLOAD,
        ST_CHECKSUM
    } state_t;

    localparam logic [7:0]  PREAMBLE_BYTE     = 8'hAA;
    localparam logic [15:0] DEFAULT_SYNC_WORD = 16'h2DD4;

    // Width of the bit-within-byte counter
    localparam int unsigned BIT_CNT_W = 3;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = '1;

endpackage

// File: rtl/bpsk_frame_tx_baud.sv
// bpsk_baud_tick: symbol-rate down-counter. tick is high on the last
// clock cycle of each bit period while enabled; load restarts a period.
module bpsk_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 41667
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // Count down through one bit period, reloading at zero or on request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (en) begin
            if (cnt == '0) begin
                cnt <= RELOAD;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign tick = en && (cnt == '0);

endmodule

// File: rtl/bpsk_frame_tx.sv
// bpsk_frame_tx: wraps streamed payload bytes in a frame (preamble, sync
// word, length, payload, XOR checksum) and serialises it MSB-first as NRZ
// at CLKS_PER_BIT clocks per symbol.
// Optional build macro BPSK_FRAME_DIFF_ENC_EN: differential encoding of DATA.
module bpsk_frame_tx
    import bpsk_frame_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT   = 41667,
    parameter int unsigned PREAMBLE_BYTES = 4,
    parameter logic [15:0] SYNC_WORD      = DEFAULT_SYNC_WORD
) (
    input  logic       CLK,
    input  logic       PB,
    input  logic       START,
    input  logic [7:0] LEN,
    input  logic [7:0] S_DATA,
    input  logic       S_VALID,
    output logic       S_READY,
    output logic       DATA,
    output logic       BIT_TICK,
    output logic       BUSY,
    output logic       DONE,
    output logic       UNDERRUN
);

`ifdef BPSK_FRAME_DIFF_ENC_EN
    localparam logic DIFF_EN = 1'b1;
`else
    localparam logic DIFF_EN = 1'b0;
`endif

    state_t               state_q;
    logic [7:0]           len_q;
    logic [7:0]           hold_q;
    logic                 hold_full_q;
    logic [7:0]           csum_q;
    logic [7:0]           accepted_q;
    logic [7:0]           sent_q;
    logic [7:0]           byte_idx_q;
    logic [BIT_CNT_W-1:0] bit_idx_q;
    logic [6:0]           shift_q;
    logic                 data_q;
    logic                 bit_tick_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 underrun_q;

    logic       tick;
    logic       load;
    logic       accept;
    logic       boundary;
    logic       need_payload;
    logic       frame_end;
    logic       bypass;
    logic       starved;
    state_t     nxt_state;
    logic [7:0] nxt_byte;
    logic [7:0] nxt_idx;

    assign load = (state_q == ST_IDLE) && START;

    bpsk_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk (CLK),
        .rst (PB),
        .load(load),
        .en  (busy_q),
        .tick(tick)
    );

    assign S_READY  = busy_q && !hold_full_q && (accepted_q < len_q);
    assign accept   = S_VALID && S_READY;
    assign boundary = tick && (bit_idx_q == LAST_BIT);
    // A byte offered exactly at the boundary with the holding register empty
    // skips the register and goes straight into the shifter.
    assign bypass   = boundary && need_payload && !hold_full_q && accept;
    assign starved  = need_payload && !hold_full_q && !accept;
    assign DATA     = data_q;
    assign BIT_TICK = bit_tick_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign UNDERRUN = underrun_q;

    // Choose the byte that follows the current one and the state it belongs to
    always_comb begin
        nxt_state    = state_q;
        nxt_byte     = PREAMBLE_BYTE;
        nxt_idx      = byte_idx_q + 8'd1;
        need_payload = 1'b0;
        frame_end    = 1'b0;
        case (state_q)
            ST_PREAMBLE: begin
                if (byte_idx_q == 8'(PREAMBLE_BYTES - 1)) begin
                    nxt_state = ST_SYNC;
                    nxt_byte  = SYNC_WORD[15:8];
                    nxt_idx   = 8'd0;
                end
            end
            ST_SYNC: begin
                if (byte_idx_q == 8'd0) begin
                    nxt_byte = SYNC_WORD[7:0];
                end else begin
                    nxt_state = ST_LENGTH;
                    nxt_byte  = len_q;
                    nxt_idx   = 8'd0;
                end
            end
            ST_LENGTH: begin
                if (len_q == 8'd0) begin
                    nxt_state = ST_CHECKSUM;
                    nxt_byte  = csum_q;
                end else begin
                    nxt_state    = ST_PAYLOAD;
                    need_payload = 1'b1;
                end
            end
            ST_PAYLOAD: begin
                if (sent_q == len_q) begin
                    nxt_state = ST_CHECKSUM;
                    nxt_byte  = csum_q;
                end else begin
                    need_payload = 1'b1;
                end
            end
            ST_CHECKSUM: frame_end = 1'b1;
            default: ;
        endcase
        if (need_payload) begin
            nxt_byte = hold_full_q ? hold_q : S_DATA;
        end
    end

    // Frame sequencer, serialiser, payload holding register and status flags
    always_ff @(posedge CLK or posedge PB) begin
        if (PB) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            csum_q      <= '0;
            accepted_q  <= '0;
            sent_q      <= '0;
            byte_idx_q  <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= 1'b0;
            bit_tick_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            bit_tick_q <= 1'b0;
            done_q     <= 1'b0;
            if (accept) begin
                accepted_q <= accepted_q + 8'd1;
            end
            if (accept && !bypass) begin
                hold_q      <= S_DATA;
                hold_full_q <= 1'b1;
            end
            if (state_q == ST_IDLE) begin
                data_q <= 1'b0;
                if (START) begin
                    // data_q is 0 in IDLE, so the encoder history starts at 0
                    state_q     <= ST_PREAMBLE;
                    len_q       <= LEN;
                    underrun_q  <= 1'b0;
                    csum_q      <= '0;
                    accepted_q  <= '0;
                    sent_q      <= '0;
                    hold_full_q <= 1'b0;
                    byte_idx_q  <= '0;
                    bit_idx_q   <= '0;
                    shift_q     <= PREAMBLE_BYTE[6:0];
                    data_q      <= PREAMBLE_BYTE[7];
                    busy_q      <= 1'b1;
                    bit_tick_q  <= 1'b1;
                end
            end else if (tick) begin
                if (!boundary) begin
                    bit_idx_q  <= bit_idx_q + 1'b1;
                    shift_q    <= {shift_q[5:0], 1'b0};
                    data_q     <= shift_q[6] ^ (DIFF_EN & data_q);
                    bit_tick_q <= 1'b1;
                end else if (frame_end) begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    data_q  <= 1'b0;
                    done_q  <= 1'b1;
                end else if (starved) begin
                    state_q    <= ST_IDLE;
                    busy_q     <= 1'b0;
                    data_q     <= 1'b0;
                    underrun_q <= 1'b1;
                end else begin
                    state_q    <= nxt_state;
                    byte_idx_q <= nxt_idx;
                    bit_idx_q  <= '0;
                    shift_q    <= nxt_byte[6:0];
                    data_q     <= nxt_byte[7] ^ (DIFF_EN & data_q);
                    bit_tick_q <= 1'b1;
                    if (need_payload) begin
                        sent_q      <= sent_q + 8'd1;
                        csum_q      <= csum_q ^ nxt_byte;
                        hold_full_q <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bpsk_frame_tx.sv
// Self-checking bench for bpsk_frame_tx (CLKS_PER_BIT=8, PREAMBLE_BYTES=2).
// Honours BPSK_FRAME_DIFF_ENC_EN in its reference model.
module tb_bpsk_frame_tx;

    localparam int          CPB = 8;
    localparam int          PRE = 2;
    localparam logic [15:0] SW  = 16'h2DD4;
`ifdef BPSK_FRAME_DIFF_ENC_EN
    localparam bit DIFF = 1'b1;
`else
    localparam bit DIFF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       pb;
    logic       start;
    logic [7:0] len;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       data;
    logic       bit_tick;
    logic       busy;
    logic       done;
    logic       underrun;

    int errors = 0;
    int checks = 0;
    bit cap[$];

    always #5 clk = ~clk;

    bpsk_frame_tx #(
        .CLKS_PER_BIT  (CPB),
        .PREAMBLE_BYTES(PRE),
        .SYNC_WORD     (SW)
    ) dut (
        .CLK     (clk),
        .PB      (pb),
        .START   (start),
        .LEN     (len),
        .S_DATA  (s_data),
        .S_VALID (s_valid),
        .S_READY (s_ready),
        .DATA    (data),
        .BIT_TICK(bit_tick),
        .BUSY    (busy),
        .DONE    (done),
        .UNDERRUN(underrun)
    );

    // Reference: frame bytes -> MSB-first bit list -> optional d[n]=b[n]^d[n-1]
    task automatic build_bits(input logic [7:0] lenv, input logic [7:0] pay[$], output bit bits[$]);
        logic [7:0] by[$];
        logic [7:0] x;
        bit b;
        bit prev;
        by = {};
        for (int i = 0; i < PRE; i++) by.push_back(8'hAA);
        by.push_back(SW[15:8]);
        by.push_back(SW[7:0]);
        by.push_back(lenv);
        x = 8'h00;
        foreach (pay[i]) begin
            by.push_back(pay[i]);
            x = x ^ pay[i];
        end
        by.push_back(x);
        bits = {};
        prev = 1'b0;
        foreach (by[i]) begin
            for (int k = 7; k >= 0; k--) begin
                b = by[i][k] ^ (DIFF & prev);
                prev = b;
                bits.push_back(b);
            end
        end
    endtask

    // Runs one frame from START, checking every cycle against the model.
    // withhold: payload index never offered (-1 none); bypass_idx: payload
    // index offered only on its boundary cycle (-1 none).
    task automatic run_frame(input string name, input logic [7:0] lenv, input logic [7:0] pay[$],
                             input int withhold, input int bypass_idx, input bit rand_valid,
                             input int glitch_at, input int abort_at);
        bit bits[$];
        int stop;
        int fed;
        bit saw_ready;
        bit offer;
        bit aborted;
        logic [4:0] got;
        logic [4:0] exp;
        build_bits(lenv, pay, bits);
        stop = (withhold >= 0) ? 8 * CPB * (PRE + 3 + withhold) : bits.size() * CPB;
        fed = 0;
        saw_ready = 1'b0;
        aborted = 1'b0;
        cap = {};
        start = 1'b1;
        len = lenv;
        @(negedge clk);
        start = 1'b0;
        len = 8'($urandom);
        for (int c = 0; c <= stop + 2; c++) begin
            got = {busy, bit_tick, data, done, underrun};
            if (c < stop) exp = {1'b1, (c % CPB) == 0, bits[c / CPB], 1'b0, 1'b0};
            else          exp = {3'b000, (c == stop) && (withhold < 0), withhold >= 0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s cycle %0d {busy,tick,data,done,underrun}: got %b expected %b",
                         name, c, got, exp);
            end
            if (c < stop && (c % CPB) == 0) cap.push_back(data);
            if (s_ready) saw_ready = 1'b1;
            if (c == abort_at) begin
                s_valid = 1'b0;
                start = 1'b0;
                #1 pb = 1'b1;
                #1;
                checks++;
                if ({busy, bit_tick, data, done, underrun, s_ready} !== 6'b0) begin
                    errors++;
                    $display("FAIL %s async_reset: got %b expected 000000", name,
                             {busy, bit_tick, data, done, underrun, s_ready});
                end
                @(negedge clk);
                pb = 1'b0;
                @(negedge clk);
                checks++;
                if ({busy, bit_tick, data, done, underrun, s_ready} !== 6'b0) begin
                    errors++;
                    $display("FAIL %s after_reset: got %b expected 000000", name,
                             {busy, bit_tick, data, done, underrun, s_ready});
                end
                aborted = 1'b1;
                break;
            end
            offer = (fed < pay.size()) && (fed != withhold)
                    && (bypass_idx != fed || c == CPB * 8 * (PRE + 3 + fed) - 1)
                    && (!rand_valid || $urandom_range(0, 1) == 1);
            s_valid = offer;
            s_data = offer ? pay[fed] : 8'($urandom);
            if (offer && s_ready) fed++;
            start = (c == glitch_at);
            @(negedge clk);
        end
        start = 1'b0;
        s_valid = 1'b0;
        if (!aborted && withhold < 0) begin
            checks++;
            if (fed != pay.size()) begin
                errors++;
                $display("FAIL %s bytes_accepted: got %0d expected %0d", name, fed, pay.size());
            end
        end
        if (lenv == 8'd0) begin
            checks++;
            if (saw_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s s_ready_len0: got %b expected 0", name, saw_ready);
            end
        end
    endtask

    task automatic test_reset();
        pb = 1'b1;
        start = 1'b0;
        len = 8'd0;
        s_data = 8'd0;
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, bit_tick, data, done, underrun, s_ready} !== 6'b0) begin
            errors++;
            $display("FAIL reset_values: got %b expected 000000",
                     {busy, bit_tick, data, done, underrun, s_ready});
        end
        pb = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, bit_tick, data, done, underrun, s_ready} !== 6'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got %b expected 000000",
                     {busy, bit_tick, data, done, underrun, s_ready});
        end
    endtask

    task automatic test_basic();
        logic [7:0] q[$];
        q = {};
        q.push_back(8'h3C);
        q.push_back(8'hC3);
        run_frame("basic", 8'd2, q, -1, -1, 1'b0, -1, -1);
    endtask

    task automatic test_len_zero();
        logic [7:0] q[$];
        q = {};
        run_frame("len_zero", 8'd0, q, -1, -1, 1'b0, -1, -1);
    endtask

    task automatic test_underrun();
        logic [7:0] q[$];
        q = {};
        q.push_back(8'h5A);
        q.push_back(8'h81);
        run_frame("underrun", 8'd2, q, 1, -1, 1'b0, -1, -1);
        q = {};
        q.push_back(8'h17);
        run_frame("underrun_clear", 8'd1, q, -1, -1, 1'b0, -1, -1);
    endtask

    task automatic test_bypass();
        logic [7:0] q[$];
        q = {};
        q.push_back(8'h96);
        q.push_back(8'h4E);
        run_frame("bypass", 8'd2, q, -1, 1, 1'b0, -1, -1);
    endtask

    task automatic test_abort();
        logic [7:0] q[$];
        q = {};
        q.push_back(8'h11);
        q.push_back(8'h22);
        q.push_back(8'h33);
        run_frame("abort", 8'd3, q, -1, -1, 1'b0, 60, 170);
    endtask

    task automatic test_payload_ff();
        logic [7:0] q[$];
        int base;
        q = {};
        q.push_back(8'hFF);
        run_frame("payload_ff", 8'd1, q, -1, -1, 1'b0, -1, -1);
        base = (PRE + 3) * 8;
        checks++;
        if (cap.size() < base + 8) begin
            errors++;
            $display("FAIL payload_ff capture_size: got %0d expected >= %0d", cap.size(), base + 8);
        end else begin
            for (int i = base; i < base + 8; i++) begin
                checks++;
                if (DIFF && cap[i] === cap[i - 1]) begin
                    errors++;
                    $display("FAIL payload_ff toggle bit %0d: got %b expected %b", i, cap[i], ~cap[i - 1]);
                end else if (!DIFF && cap[i] !== 1'b1) begin
                    errors++;
                    $display("FAIL payload_ff level bit %0d: got %b expected 1", i, cap[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        int n;
        int g;
        for (int it = 0; it < 4; it++) begin
            n = $urandom_range(0, 5);
            q = {};
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            g = $urandom_range(1, (PRE + 3 + n) * 8 * CPB - 2);
            run_frame("random", 8'(n), q, -1, -1, 1'b1, g, -1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_zero();
        test_underrun();
        test_bypass();
        test_abort();
        test_payload_ff();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
